// File: rtl/osd_spi_master_if.sv
`default_nettype none
// ============================================================================
// Module      : osd_spi_master_if
// Description : Byte-stream handshake between a byte producer and the OSD
//               SPI master. One byte moves on every cycle where tx_valid and
//               tx_ready are both high; tx_last marks the final byte of a frame.
//   tx_data  [7:0]  byte to send                  (producer -> master)
//   tx_valid        tx_data is valid              (producer -> master)
//   tx_last         this byte ends the frame      (producer -> master)
//   tx_ready        master accepts the byte       (master -> producer)
//   modport master : the byte producer side
//   modport slave  : the SPI master (byte consumer) side
// Revision    : 1.0  initial release
// ============================================================================
interface osd_spi_master_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/osd_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : osd_spi_master
// Description : SPI mode-0 master for the OSD serial port (SCK/SS3/DI).
//               Serialises a byte stream MSB-first; the first byte of each
//               frame is the OSD command, the rest is payload. SS3 stays low
//               across all bytes of a frame and is held high for at least
//               GAP_CYCLES between frames. All outputs are registered.
//   clk_sys         master clock, rising edge
//   reset_n         synchronous active-low reset
//   tx (slave)      tx_data/tx_valid/tx_last in, tx_ready out
//   busy            first-byte accept until end of inter-frame gap
//   byte_done       one-cycle pulse on the SCK fall after bit 0 of a byte
//   SPI_SCK         serial clock, idles low
//   SPI_SS3         OSD select, active low, idles high
//   SPI_DI          serial data, MSB first
// Revision    : 1.0  initial release
// ============================================================================
module osd_spi_master #(
    parameter int CLK_DIV    = 4,   // clk_sys cycles per SCK half-period, 1..255
    parameter int GAP_CYCLES = 4    // minimum SS3-high cycles between frames, 1..255
) (
    input  wire logic          clk_sys,
    input  wire logic          reset_n,
    osd_spi_master_if.slave    tx,
    output logic               busy,
    output logic               byte_done,
    output logic               SPI_SCK,
    output logic               SPI_SS3,
    output logic               SPI_DI
);

    localparam logic [7:0] C_DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] C_GAP_RELOAD = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOW  = 3'd1,
        S_HIGH = 3'd2,
        S_WAIT = 3'd3,
        S_HOLD = 3'd4,
        S_GAP  = 3'd5
    } state_t;

    state_t     r_state,    w_state;
    logic [7:0] r_shift,    w_shift;
    logic       r_last,     w_last;
    logic [2:0] r_bit_cnt,  w_bit_cnt;
    logic [7:0] r_half_cnt, w_half_cnt;
    logic       r_sck,      w_sck;
    logic       r_ss3,      w_ss3;
    logic       r_di,       w_di;
    logic       r_tx_ready, w_tx_ready;
    logic       r_busy,     w_busy;
    logic       r_byte_done, w_byte_done;
    logic       w_accept;

    // tx_ready is only ever high in IDLE/WAIT, so it alone qualifies an accept.
    assign w_accept = tx.tx_valid & r_tx_ready;

    always_comb begin
        w_state     = r_state;
        w_shift     = r_shift;
        w_last      = r_last;
        w_bit_cnt   = r_bit_cnt;
        w_half_cnt  = r_half_cnt;
        w_sck       = r_sck;
        w_ss3       = r_ss3;
        w_di        = r_di;
        w_tx_ready  = r_tx_ready;
        w_busy      = r_busy;
        w_byte_done = 1'b0;

        case (r_state)
            S_IDLE, S_WAIT: begin
                if (r_state == S_IDLE) begin
                    w_ss3 = 1'b1;
                    w_sck = 1'b0;
                end
                w_tx_ready = 1'b1;
                if (w_accept) begin
                    w_shift    = tx.tx_data;
                    w_last     = tx.tx_last;
                    w_bit_cnt  = 3'd7;
                    w_half_cnt = C_DIV_RELOAD;
                    w_ss3      = 1'b0;
                    w_di       = tx.tx_data[7];
                    w_tx_ready = 1'b0;
                    w_busy     = 1'b1;
                    w_state    = S_LOW;
                end
            end

            S_LOW: begin
                if (r_half_cnt == 8'd0) begin
                    w_sck      = 1'b1;
                    w_half_cnt = C_DIV_RELOAD;
                    w_state    = S_HIGH;
                end else begin
                    w_half_cnt = r_half_cnt - 8'd1;
                end
            end

            S_HIGH: begin
                if (r_half_cnt == 8'd0) begin
                    w_sck       = 1'b0;
                    w_byte_done = (r_bit_cnt == 3'd0);
                    w_half_cnt  = C_DIV_RELOAD;
                    if (r_bit_cnt != 3'd0) begin
                        // Rotate rather than shift: bit [6] is always the next
                        // bit out, and the byte stays whole in the register.
                        w_shift   = {r_shift[6:0], r_shift[7]};
                        w_di      = r_shift[6];
                        w_bit_cnt = r_bit_cnt - 3'd1;
                        w_state   = S_LOW;
                    end else if (r_last) begin
                        w_state = S_HOLD;
                    end else begin
                        w_tx_ready = 1'b1;
                        w_state    = S_WAIT;
                    end
                end else begin
                    w_half_cnt = r_half_cnt - 8'd1;
                end
            end

            // SS3 held low one more half-period after the final SCK fall.
            S_HOLD: begin
                if (r_half_cnt == 8'd0) begin
                    w_ss3      = 1'b1;
                    w_half_cnt = C_GAP_RELOAD;
                    w_state    = S_GAP;
                end else begin
                    w_half_cnt = r_half_cnt - 8'd1;
                end
            end

            S_GAP: begin
                if (r_half_cnt == 8'd0) begin
                    w_tx_ready = 1'b1;
                    w_busy     = 1'b0;
                    w_state    = S_IDLE;
                end else begin
                    w_half_cnt = r_half_cnt - 8'd1;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_shift     <= 8'd0;
            r_last      <= 1'b0;
            r_bit_cnt   <= 3'd0;
            r_half_cnt  <= 8'd0;
            r_sck       <= 1'b0;
            r_ss3       <= 1'b1;
            r_di        <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_byte_done <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_shift     <= w_shift;
            r_last      <= w_last;
            r_bit_cnt   <= w_bit_cnt;
            r_half_cnt  <= w_half_cnt;
            r_sck       <= w_sck;
            r_ss3       <= w_ss3;
            r_di        <= w_di;
            r_tx_ready  <= w_tx_ready;
            r_busy      <= w_busy;
            r_byte_done <= w_byte_done;
        end
    end

    assign tx.tx_ready = r_tx_ready;
    assign busy        = r_busy;
    assign byte_done   = r_byte_done;
    assign SPI_SCK     = r_sck;
    assign SPI_SS3     = r_ss3;
    assign SPI_DI      = r_di;

endmodule
`default_nettype wire

// File: tb/tb_osd_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_osd_spi_master
// Description : Directed self-checking bench for osd_spi_master. Instance A
//               runs CLK_DIV=2/GAP_CYCLES=4, instance B runs CLK_DIV=1.
//               Per-instance monitors record DI at every SCK rise and count
//               SS3-low cycles, SS3 falls, byte_done pulses and SS3-high runs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_osd_spi_master;

    logic clk_sys = 1'b0;
    logic reset_n;
    always #5 clk_sys = ~clk_sys;

    osd_spi_master_if bus_a ();
    osd_spi_master_if bus_b ();

    logic busy_a, done_a, sck_a, ss3_a, di_a;
    logic busy_b, done_b, sck_b, ss3_b, di_b;

    osd_spi_master #(.CLK_DIV(2), .GAP_CYCLES(4)) u_dut_a (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .tx        (bus_a.slave),
        .busy      (busy_a),
        .byte_done (done_a),
        .SPI_SCK   (sck_a),
        .SPI_SS3   (ss3_a),
        .SPI_DI    (di_a)
    );

    osd_spi_master #(.CLK_DIV(1), .GAP_CYCLES(4)) u_dut_b (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .tx        (bus_b.slave),
        .busy      (busy_b),
        .byte_done (done_b),
        .SPI_SCK   (sck_b),
        .SPI_SS3   (ss3_b),
        .SPI_DI    (di_b)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- monitor A ----------------
    int   rise_a = 0, low_a = 0, falls_a = 0, dcnt_a = 0, viol_a = 0;
    int   hi_run_a = 0, last_hi_a = 0;
    logic bits_a [0:1023];
    logic prev_sck_a = 1'b0, prev_ss3_a = 1'b1;

    always @(negedge clk_sys) begin
        if (!prev_sck_a && sck_a === 1'b1) begin
            bits_a[rise_a] = di_a;
            rise_a++;
            if (ss3_a === 1'b1) viol_a++;
        end
        if (ss3_a === 1'b0) low_a++;
        if (prev_ss3_a && ss3_a === 1'b0) begin
            falls_a++;
            last_hi_a = hi_run_a;
        end
        if (ss3_a === 1'b1) hi_run_a++; else hi_run_a = 0;
        if (done_a === 1'b1) dcnt_a++;
        prev_sck_a = (sck_a === 1'b1);
        prev_ss3_a = (ss3_a !== 1'b0);
    end

    // ---------------- monitor B ----------------
    int   rise_b = 0, low_b = 0;
    logic bits_b [0:1023];
    logic prev_sck_b = 1'b0;

    always @(negedge clk_sys) begin
        if (!prev_sck_b && sck_b === 1'b1) begin
            bits_b[rise_b] = di_b;
            rise_b++;
        end
        if (ss3_b === 1'b0) low_b++;
        prev_sck_b = (sck_b === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents one byte on bus A and returns on the negedge after its accept.
    task automatic send_a(input logic [7:0] d, input logic l);
        int t;
        bus_a.tx_data  = d;
        bus_a.tx_last  = l;
        bus_a.tx_valid = 1'b1;
        t = 0;
        while (bus_a.tx_ready !== 1'b1 && t < 300) begin
            @(negedge clk_sys);
            t++;
        end
        checks++;
        if (bus_a.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_a_timeout: tx_ready=%b required 1", bus_a.tx_ready);
        end
        @(negedge clk_sys);
        bus_a.tx_valid = 1'b0;
    endtask

    task automatic wait_idle_a();
        int t;
        t = 0;
        while (busy_a !== 1'b0 && t < 2000) begin
            @(negedge clk_sys);
            t++;
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout_a: busy=%b required 0", busy_a);
        end
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        bus_a.tx_data  = 8'h00; bus_a.tx_valid = 1'b0; bus_a.tx_last = 1'b0;
        bus_b.tx_data  = 8'h00; bus_b.tx_valid = 1'b0; bus_b.tx_last = 1'b0;
        repeat (3) @(negedge clk_sys);
        checks++;
        if ({ss3_a, sck_a, di_a, bus_a.tx_ready, busy_a, done_a} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_outputs_a: ss3,sck,di,rdy,busy,done=%b required 100000",
                     {ss3_a, sck_a, di_a, bus_a.tx_ready, busy_a, done_a});
        end
        checks++;
        if ({ss3_b, sck_b, di_b, bus_b.tx_ready, busy_b, done_b} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_outputs_b: ss3,sck,di,rdy,busy,done=%b required 100000",
                     {ss3_b, sck_b, di_b, bus_b.tx_ready, busy_b, done_b});
        end
        reset_n = 1'b1;
        @(negedge clk_sys);
        checks++;
        if (bus_a.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: tx_ready=%b required 1", bus_a.tx_ready);
        end
    endtask

    task automatic test_single();
        int r0, l0, d0, n, t;
        logic [7:0] got;
        r0 = rise_a; l0 = low_a; d0 = dcnt_a;
        send_a(8'h41, 1'b1);
        checks++;
        if (ss3_a !== 1'b0) begin
            errors++;
            $display("FAIL single_ss3_start: ss3=%b required 0 one cycle after accept", ss3_a);
        end
        t = 0;
        while (ss3_a !== 1'b1 && t < 200) begin
            @(negedge clk_sys);
            t++;
        end
        // now on the first SS3-high cycle; tx_ready should appear on the fifth
        n = 1;
        while (bus_a.tx_ready !== 1'b1 && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        checks++;
        if (n != 5 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL single_ready_return: ready on high cycle %0d busy=%b required 5 busy=0",
                     n, busy_a);
        end
        repeat (2) @(negedge clk_sys);
        checks++;
        if (low_a - l0 != 34) begin
            errors++;
            $display("FAIL single_ss3_low: %0d cycles required 34", low_a - l0);
        end
        checks++;
        if (rise_a - r0 != 8 || dcnt_a - d0 != 1) begin
            errors++;
            $display("FAIL single_edges: rises=%0d done=%0d required 8 and 1",
                     rise_a - r0, dcnt_a - d0);
        end
        for (int i = 0; i < 8; i++) got[7-i] = bits_a[r0+i];
        checks++;
        if (got !== 8'h41) begin
            errors++;
            $display("FAIL single_data: got %h required 41", got);
        end
    endtask

    task automatic test_back_to_back();
        int r0, l0, d0, f0;
        logic [7:0]  frame [4];
        logic [31:0] got;
        frame = '{8'h20, 8'h00, 8'hFF, 8'h5A};
        r0 = rise_a; l0 = low_a; d0 = dcnt_a; f0 = falls_a;
        for (int k = 0; k < 4; k++) send_a(frame[k], (k == 3));
        wait_idle_a();
        checks++;
        if (low_a - l0 != 133 || falls_a - f0 != 1) begin
            errors++;
            $display("FAIL b2b_ss3_low: %0d cycles in %0d runs required 133 in 1",
                     low_a - l0, falls_a - f0);
        end
        checks++;
        if (rise_a - r0 != 32 || dcnt_a - d0 != 4) begin
            errors++;
            $display("FAIL b2b_edges: rises=%0d done=%0d required 32 and 4",
                     rise_a - r0, dcnt_a - d0);
        end
        for (int i = 0; i < 32; i++) got[31-i] = bits_a[r0+i];
        checks++;
        if (got !== 32'h2000FF5A) begin
            errors++;
            $display("FAIL b2b_data: got %h required 2000ff5a", got);
        end
    endtask

    task automatic test_stall();
        int r0, l0, f0, t;
        logic        stall_bad;
        logic [7:0]  frame [4];
        logic [31:0] got;
        frame = '{8'h20, 8'h00, 8'hFF, 8'h5A};
        r0 = rise_a; l0 = low_a; f0 = falls_a;
        stall_bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_a(frame[k], (k == 3));
            if (k == 1) begin
                t = 0;
                while (bus_a.tx_ready !== 1'b1 && t < 100) begin
                    @(negedge clk_sys);
                    t++;
                end
                repeat (10) begin
                    if (sck_a !== 1'b0 || ss3_a !== 1'b0) stall_bad = 1'b1;
                    @(negedge clk_sys);
                end
            end
        end
        wait_idle_a();
        checks++;
        if (stall_bad !== 1'b0) begin
            errors++;
            $display("FAIL stall_lines: sck/ss3 moved during stall, flag=%b required 0", stall_bad);
        end
        checks++;
        if (low_a - l0 != 143 || falls_a - f0 != 1) begin
            errors++;
            $display("FAIL stall_ss3_low: %0d cycles in %0d runs required 143 in 1",
                     low_a - l0, falls_a - f0);
        end
        for (int i = 0; i < 32; i++) got[31-i] = bits_a[r0+i];
        checks++;
        if (rise_a - r0 != 32 || got !== 32'h2000FF5A) begin
            errors++;
            $display("FAIL stall_data: rises=%0d got %h required 32 and 2000ff5a",
                     rise_a - r0, got);
        end
    endtask

    task automatic test_clk_div1();
        int r0, l0, t;
        logic [15:0] sck_pat;
        logic [7:0]  got;
        r0 = rise_b; l0 = low_b;
        bus_b.tx_data = 8'hA5; bus_b.tx_last = 1'b1; bus_b.tx_valid = 1'b1;
        t = 0;
        while (bus_b.tx_ready !== 1'b1 && t < 100) begin
            @(negedge clk_sys);
            t++;
        end
        @(negedge clk_sys);
        bus_b.tx_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sck_pat[i] = sck_b;
            @(negedge clk_sys);
        end
        t = 0;
        while (busy_b !== 1'b0 && t < 200) begin
            @(negedge clk_sys);
            t++;
        end
        repeat (2) @(negedge clk_sys);
        checks++;
        if (sck_pat !== 16'hAAAA) begin
            errors++;
            $display("FAIL div1_sck_toggle: pattern %h required aaaa", sck_pat);
        end
        checks++;
        if (low_b - l0 != 17 || rise_b - r0 != 8) begin
            errors++;
            $display("FAIL div1_timing: low=%0d rises=%0d required 17 and 8",
                     low_b - l0, rise_b - r0);
        end
        for (int i = 0; i < 8; i++) got[7-i] = bits_b[r0+i];
        checks++;
        if (got !== 8'hA5) begin
            errors++;
            $display("FAIL div1_data: got %h required a5", got);
        end
    endtask

    task automatic test_reset_mid();
        int r0, l0;
        logic [7:0] got;
        send_a(8'h20, 1'b0);
        send_a(8'h5A, 1'b1);
        // 14 cycles in: HIGH phase of bit 4 of the second byte (DI=1)
        repeat (14) @(negedge clk_sys);
        reset_n = 1'b0;
        @(negedge clk_sys);
        checks++;
        if ({ss3_a, sck_a, di_a, bus_a.tx_ready, busy_a, done_a} !== 6'b100000) begin
            errors++;
            $display("FAIL midreset_outputs: ss3,sck,di,rdy,busy,done=%b required 100000",
                     {ss3_a, sck_a, di_a, bus_a.tx_ready, busy_a, done_a});
        end
        reset_n = 1'b1;
        @(negedge clk_sys);
        checks++;
        if (bus_a.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: tx_ready=%b required 1", bus_a.tx_ready);
        end
        r0 = rise_a; l0 = low_a;
        send_a(8'h41, 1'b1);
        wait_idle_a();
        for (int i = 0; i < 8; i++) got[7-i] = bits_a[r0+i];
        checks++;
        if (got !== 8'h41 || rise_a - r0 != 8 || low_a - l0 != 34) begin
            errors++;
            $display("FAIL midreset_frame: data %h rises %0d low %0d required 41 8 34",
                     got, rise_a - r0, low_a - l0);
        end
    endtask

    task automatic test_backpressure();
        int r0;
        logic [15:0] got;
        r0 = rise_a;
        send_a(8'h41, 1'b1);
        send_a(8'hC3, 1'b1);
        @(negedge clk_sys);
        checks++;
        if (last_hi_a != 5) begin
            errors++;
            $display("FAIL bp_gap: ss3 high %0d cycles between frames required 5", last_hi_a);
        end
        wait_idle_a();
        for (int i = 0; i < 16; i++) got[15-i] = bits_a[r0+i];
        checks++;
        if (got !== 16'h41C3 || rise_a - r0 != 16) begin
            errors++;
            $display("FAIL bp_data: got %h rises %0d required 41c3 and 16", got, rise_a - r0);
        end
        checks++;
        if (viol_a != 0) begin
            errors++;
            $display("FAIL sck_while_deselected: %0d rises with ss3 high required 0", viol_a);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_clk_div1();
        test_reset_mid();
        test_backpressure();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
